// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves stall/flush controls for a 5-stage pipeline,
// tracks data-memory wait timeouts and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [7:0]       wcnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  logic in_err;
  logic mem_wait;
  logic load_use;
  logic hit_timeout;
  logic branch_fire;

  assign in_err      = (state_reg == ST_ERR);
  assign mem_wait    = dmem_req & ~dmem_ready;
  assign load_use    = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  assign hit_timeout = ~in_err & mem_wait & (({1'b0, wcnt_reg} + 9'd1) == 9'(TIMEOUT));
  assign branch_fire = ~in_err & ~mem_wait & branch_taken;

  // Priority: error, memory wait, taken branch, load-use, fetch miss.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (in_err || mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
      wcnt_reg  <= 8'd0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (mem_wait) begin
            state_reg <= hit_timeout ? ST_ERR : ST_WAIT;
            wcnt_reg  <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (mem_wait) begin
            if (hit_timeout) state_reg <= ST_ERR;
            wcnt_reg <= wcnt_reg + 8'd1;
          end else begin
            state_reg <= ST_RUN;
            wcnt_reg  <= 8'd0;
          end
        end
        ST_ERR: begin
          state_reg <= ST_ERR;
        end
        default: begin
          state_reg <= ST_RUN;
          wcnt_reg  <= 8'd0;
        end
      endcase
    end
  end

  // The edge that enters ERR already belongs to the error episode, so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (cnt_clr) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (pc_stall && !in_err && !hit_timeout && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (branch_fire && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign state        = state_reg;
  assign mem_timeout  = in_err;
  assign stall_cycles = stall_cnt_reg;
  assign flush_count  = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (TIMEOUT=4 main instance,
// TIMEOUT=1 second instance for the immediate-timeout boundary).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, ex_mem_read, branch_taken;
  logic        imem_ready, dmem_req, dmem_ready, cnt_clr;

  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cycles, flush_count;

  logic        u1_pc_stall, u1_if_id_stall, u1_id_ex_stall, u1_ex_mem_stall;
  logic        u1_if_id_flush, u1_id_ex_flush;
  logic [1:0]  u1_state;
  logic        u1_mem_timeout;
  logic [15:0] u1_stall_cycles, u1_flush_count;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .cnt_clr(cnt_clr), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .cnt_clr(cnt_clr), .pc_stall(u1_pc_stall),
    .if_id_stall(u1_if_id_stall), .id_ex_stall(u1_id_ex_stall),
    .ex_mem_stall(u1_ex_mem_stall), .if_id_flush(u1_if_id_flush),
    .id_ex_flush(u1_id_ex_flush), .state(u1_state), .mem_timeout(u1_mem_timeout),
    .stall_cycles(u1_stall_cycles), .flush_count(u1_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex flushes}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LU   = 6'b110001;
  localparam logic [5:0] BR   = 6'b000011;
  localparam logic [5:0] IM   = 6'b100010;
  localparam logic [5:0] STL  = 6'b111100;

  typedef struct {
    string       tag;
    logic        sel;
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic        mt;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic cmp(input string tag, input string fld, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic sel, input logic [5:0] ctl,
                      input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ctl = ctl; e.st = st;
    e.mt = (st == 2'd2); e.sc = sc; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [5:0] o_ctl;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      o_ctl = {u1_pc_stall, u1_if_id_stall, u1_id_ex_stall, u1_ex_mem_stall,
               u1_if_id_flush, u1_id_ex_flush};
      cmp(e.tag, "ctl", {10'd0, o_ctl}, {10'd0, e.ctl});
      cmp(e.tag, "state", {14'd0, u1_state}, {14'd0, e.st});
      cmp(e.tag, "mem_timeout", {15'd0, u1_mem_timeout}, {15'd0, e.mt});
      cmp(e.tag, "stall_cycles", u1_stall_cycles, e.sc);
      cmp(e.tag, "flush_count", u1_flush_count, e.fc);
    end else begin
      o_ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};
      cmp(e.tag, "ctl", {10'd0, o_ctl}, {10'd0, e.ctl});
      cmp(e.tag, "state", {14'd0, state}, {14'd0, e.st});
      cmp(e.tag, "mem_timeout", {15'd0, mem_timeout}, {15'd0, e.mt});
      cmp(e.tag, "stall_cycles", stall_cycles, e.sc);
      cmp(e.tag, "flush_count", flush_count, e.fc);
    end
    $display("[TB] %s checked (inst %0d)", e.tag, e.sel);
  endtask

  task automatic chk(input string tag, input logic sel, input logic [5:0] ctl,
                     input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
    push(tag, sel, ctl, st, sc, fc);
    pop_check();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load_use_rs5();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    #2;
    chk("reset", 0, NONE, 2'd0, 16'd0, 16'd0);
    chk("reset_u1", 1, NONE, 2'd0, 16'd0, 16'd0);
    @(negedge clk) rst = 1'b0;

    // Load-use on rs
    @(negedge clk) idle(); load_use_rs5();
    #1 chk("lu_comb", 0, LU, 2'd0, 16'd0, 16'd0);
    tick(); chk("lu_edge", 0, LU, 2'd0, 16'd1, 16'd0);

    // Load to r0 never hazards
    @(negedge clk) ex_rd = 5'd0; id_rs = 5'd0;
    #1 chk("r0_comb", 0, NONE, 2'd0, 16'd1, 16'd0);
    tick(); chk("r0_edge", 0, NONE, 2'd0, 16'd1, 16'd0);

    // Load-use on rt, then same register with use flag dropped
    @(negedge clk) idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
    id_rs = 5'd7;
    #1 chk("lu_rt_comb", 0, LU, 2'd0, 16'd1, 16'd0);
    tick(); chk("lu_rt_edge", 0, LU, 2'd0, 16'd2, 16'd0);
    @(negedge clk) id_use_rt = 1'b0;
    #1 chk("rt_unused", 0, NONE, 2'd0, 16'd2, 16'd0);

    // Taken branch wins over load-use
    @(negedge clk) idle(); load_use_rs5(); branch_taken = 1'b1;
    #1 chk("br_lu_comb", 0, BR, 2'd0, 16'd2, 16'd0);
    tick(); chk("br_lu_edge", 0, BR, 2'd0, 16'd2, 16'd1);

    // Fetch not ready
    @(negedge clk) idle(); imem_ready = 1'b0;
    #1 chk("imem_comb", 0, IM, 2'd0, 16'd2, 16'd1);
    tick(); chk("imem_edge", 0, IM, 2'd0, 16'd3, 16'd1);

    // Clear has priority over a stall increment
    @(negedge clk) idle(); load_use_rs5(); cnt_clr = 1'b1;
    #1 chk("clr_comb", 0, LU, 2'd0, 16'd3, 16'd1);
    tick(); chk("clr_edge", 0, LU, 2'd0, 16'd0, 16'd0);

    // Wait release after two edges; TIMEOUT=1 instance errors on the first
    @(negedge clk) idle(); dmem_req = 1'b1;
    #1 chk("wait_comb", 0, STL, 2'd0, 16'd0, 16'd0);
    chk("wait_comb_u1", 1, STL, 2'd0, 16'd0, 16'd0);
    tick(); chk("wait_e1", 0, STL, 2'd1, 16'd1, 16'd0);
    chk("t1_err_u1", 1, STL, 2'd2, 16'd0, 16'd0);
    tick(); chk("wait_e2", 0, STL, 2'd1, 16'd2, 16'd0);
    @(negedge clk) dmem_ready = 1'b1;
    #1 chk("release_comb", 0, NONE, 2'd1, 16'd2, 16'd0);
    tick(); chk("release_edge", 0, NONE, 2'd0, 16'd2, 16'd0);

    @(negedge clk) idle(); cnt_clr = 1'b1;
    tick(); chk("clr_idle", 0, NONE, 2'd0, 16'd0, 16'd0);

    // Fresh wait restarts wcnt at 1: ERR only on the fourth edge
    @(negedge clk) idle(); dmem_req = 1'b1;
    tick(); chk("to_e1", 0, STL, 2'd1, 16'd1, 16'd0);
    tick(); chk("to_e2", 0, STL, 2'd1, 16'd2, 16'd0);
    tick(); chk("to_e3", 0, STL, 2'd1, 16'd3, 16'd0);
    tick(); chk("to_e4", 0, STL, 2'd2, 16'd3, 16'd0);

    @(negedge clk) dmem_ready = 1'b1;
    #1 chk("err_ready_comb", 0, STL, 2'd2, 16'd3, 16'd0);
    tick(); chk("err_ready_edge", 0, STL, 2'd2, 16'd3, 16'd0);
    @(negedge clk) idle(); branch_taken = 1'b1;
    #1 chk("err_br_comb", 0, STL, 2'd2, 16'd3, 16'd0);
    tick(); chk("err_br_edge", 0, STL, 2'd2, 16'd3, 16'd0);

    // Asynchronous reset out of ERR, no clock edge
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_err", 0, BR, 2'd0, 16'd0, 16'd0);
    chk("rst_err_u1", 1, BR, 2'd0, 16'd0, 16'd0);
    @(negedge clk) rst = 1'b0; idle();
    tick(); chk("post_rst", 0, NONE, 2'd0, 16'd0, 16'd0);

    // Asynchronous reset mid-WAIT
    @(negedge clk) dmem_req = 1'b1;
    tick(); chk("mid_wait", 0, STL, 2'd1, 16'd1, 16'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_wait", 0, STL, 2'd0, 16'd0, 16'd0);
    @(negedge clk) rst = 1'b0; idle();

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
